// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that writes a length-prefixed program into instruction memory
//
// Ports:
//   clk, reset     single clock; asynchronous active-low reset
//   start          single-cycle request to begin a load (honoured in IDLE, DONE, ERR)
//   in_valid       byte-stream valid
//   in_data        byte-stream payload
//   in_ready       loader accepts a byte this cycle
//   mem_we         instruction-memory write strobe
//   mem_addr       instruction-memory word address (registered)
//   mem_wdata      instruction word to write (registered)
//   core_hold      holds the core in reset while 1
//   busy           load in progress
//   done           last load completed without error
//   err            last load aborted: length exceeded MAX_WORDS
module imem_loader #(
  parameter int          ADDR_W    = 13,
  parameter int unsigned MAX_WORDS = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     len;
  logic [ADDR_W:0] wcnt;      // one extra bit so a full-size program does not wrap
  logic [1:0]      bidx;
  logic [23:0]     shift;     // first three bytes of the word being assembled

  logic            xfer;
  logic [15:0]     len_new;
  logic [ADDR_W:0] wcnt_inc;

  assign xfer     = in_valid & in_ready;
  assign len_new  = {len[15:8], in_data};
  assign wcnt_inc = wcnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    core_hold = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          if (len_new == 16'd0)                state_nxt = DONE;
          else if (32'(len_new) > MAX_WORDS)   state_nxt = ERR;
          else                                 state_nxt = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && bidx == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (32'(wcnt_inc) == 32'(len)) state_nxt = DONE;
        else                            state_nxt = DATA;
      end
      DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
        if (start) state_nxt = LEN_HI;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_nxt = LEN_HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and data are latched on the fourth byte so they are already
  // stable during the single WRITE cycle and hold afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len       <= '0;
      wcnt      <= '0;
      bidx      <= '0;
      shift     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            len  <= '0;
            wcnt <= '0;
            bidx <= '0;
          end
        end
        LEN_HI: if (xfer) len[15:8] <= in_data;
        LEN_LO: if (xfer) len[7:0]  <= in_data;
        DATA: begin
          if (xfer) begin
            shift <= {shift[15:0], in_data};
            bidx  <= bidx + 1'b1;   // wraps 3 -> 0 on the word's last byte
            if (bidx == 2'd3) begin
              mem_wdata <= {shift, in_data};
              mem_addr  <= wcnt[ADDR_W-1:0];
            end
          end
        end
        WRITE: wcnt <= wcnt_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a write scoreboard
module tb_imem_loader;

  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(8192)) dut (
    .clk(clk), .reset(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int wr_count = 0;

  typedef struct packed { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
  wr_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      wr_count++;
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e.addr));
        chk("write_data", mem_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  logic [7:0] prog2 [10];
  int wc;

  initial begin
    prog2 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h2A};
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // two-word program, back-to-back bytes
    push(0, 32'h2008_0005);
    push(1, 32'h0000_002A);
    do_start();
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_hold", 32'(core_hold), 32'd1);
    for (int i = 0; i < 10; i++) send_byte(prog2[i], 0);
    chk("s1_we_last",   32'(mem_we), 32'd1);
    chk("s1_hold_last", 32'(core_hold), 32'd1);
    @(negedge clk);
    chk("s1_done",  32'(done), 32'd1);
    chk("s1_hold",  32'(core_hold), 32'd0);
    chk("s1_busy0", 32'(busy), 32'd0);
    chk("s1_we0",   32'(mem_we), 32'd0);
    chk("s1_addr_hold",  32'(mem_addr), 32'd1);
    chk("s1_wdata_hold", mem_wdata, 32'h0000_002A);
    chk("s1_writes", 32'(wr_count), 32'd2);

    // zero-length program
    wc = wr_count;
    do_start();
    chk("s2_done_cleared", 32'(done), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_hold", 32'(core_hold), 32'd0);
    chk("s2_no_writes", 32'(wr_count), 32'(wc));

    // reload from DONE overwrites address 0
    push(0, 32'h0000_0008);
    do_start();
    chk("s3_hold_rise", 32'(core_hold), 32'd1);
    chk("s3_done_fall", 32'(done), 32'd0);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h08, 0);
    @(negedge clk);
    chk("s3_done", 32'(done), 32'd1);
    chk("s3_hold", 32'(core_hold), 32'd0);

    // two-word program with random stalls between bytes
    push(0, 32'h2008_0005);
    push(1, 32'h0000_002A);
    wc = wr_count;
    do_start();
    for (int i = 0; i < 10; i++) send_byte(prog2[i], int'($urandom_range(3, 0)));
    chk("s4_we_last", 32'(mem_we), 32'd1);
    @(negedge clk);
    chk("s4_done", 32'(done), 32'd1);
    chk("s4_hold", 32'(core_hold), 32'd0);
    chk("s4_writes", 32'(wr_count - wc), 32'd2);

    // oversize length -> ERR
    wc = wr_count;
    do_start();
    send_byte(8'h20, 0);
    send_byte(8'h01, 0);
    chk("s5_err",      32'(err), 32'd1);
    chk("s5_hold",     32'(core_hold), 32'd1);
    chk("s5_in_ready", 32'(in_ready), 32'd0);
    chk("s5_busy",     32'(busy), 32'd0);
    chk("s5_done",     32'(done), 32'd0);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    chk("s5_err_stays", 32'(err), 32'd1);
    chk("s5_no_writes", 32'(wr_count), 32'(wc));

    // LEN = MAX_WORDS is accepted; then reset mid-data
    do_start();
    chk("s6_err_cleared", 32'(err), 32'd0);
    send_byte(8'h20, 0);
    send_byte(8'h00, 0);
    chk("s6_max_busy",  32'(busy), 32'd1);
    chk("s6_max_err",   32'(err), 32'd0);
    chk("s6_max_ready", 32'(in_ready), 32'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_ready", 32'(in_ready), 32'd0);
    chk("s6_rst_we",    32'(mem_we), 32'd0);
    chk("s6_rst_addr",  32'(mem_addr), 32'd0);
    chk("s6_rst_wdata", mem_wdata, 32'd0);
    chk("s6_rst_hold",  32'(core_hold), 32'd1);
    chk("s6_rst_busy",  32'(busy), 32'd0);
    chk("s6_rst_done",  32'(done), 32'd0);
    chk("s6_rst_err",   32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(0, 32'hDEAD_BEEF);
    do_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    @(negedge clk);
    chk("s6_done", 32'(done), 32'd1);
    chk("s6_hold", 32'(core_hold), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 13: instruction-memory word-address width, matching the 13-bit PC.
REQ-002 SHALL have parameter MAX_WORDS, default 8192: largest accepted program length in words.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a program load.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  loader can accept a byte; a byte transfers on a cycle with in_valid=1 and in_ready=1.
REQ-009 mem_we  output  1  instruction-memory write strobe.
REQ-010 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 mem_wdata  output  32  instruction word to write.
REQ-012 core_hold  output  1  holds the processor core in reset while 1.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  last load completed without error.
REQ-015 err  output  1  last load aborted because the length exceeded MAX_WORDS.

Function
REQ-016 Stream format SHALL be 16-bit word count LEN, big-endian (2 bytes), then LEN words of 4 bytes each, big-endian (first byte = bits 31:24).
REQ-017 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR, all registered.
REQ-018 IDLE: in_ready=0; start=1 -> LEN_HI, word counter and byte index cleared to 0, core_hold=1.
REQ-019 LEN_HI: in_ready=1; on transfer, capture LEN[15:8] -> LEN_LO.
REQ-020 LEN_LO: in_ready=1; on transfer, capture LEN[7:0]; next state DONE if LEN=0, ERR if LEN>MAX_WORDS, else DATA.
REQ-021 DATA: in_ready=1; each transfer shifts the byte into the word assembler and increments byte index 0..3; the transfer at index 3 -> WRITE with index reset to 0.
REQ-022 WRITE: in_ready=0; mem_we=1 for exactly one cycle with mem_addr=word counter and mem_wdata=assembled word; word counter increments; next state DONE if incremented count equals LEN, else DATA.
REQ-023 DONE: done=1, busy=0, core_hold=0; start=1 -> LEN_HI with counters cleared, done=0, core_hold=1.
REQ-024 ERR: err=1, busy=0, core_hold=1, in_ready=0, no writes; exits only via start (-> LEN_HI, err=0) or reset.
REQ-025 busy SHALL be 1 in LEN_HI, LEN_LO, DATA, WRITE and 0 otherwise.
REQ-026 start SHALL be ignored in LEN_HI, LEN_LO, DATA, WRITE.
REQ-027 No byte SHALL be consumed on a cycle with in_valid=0; stalls of any length between bytes SHALL not change the result.
REQ-028 mem_we SHALL be 0 outside WRITE; mem_addr and mem_wdata SHALL be registered and hold their last values between writes.
REQ-029 Word counter SHALL be ADDR_W+1 bits wide, so LEN=MAX_WORDS=8192 writes addresses 0..8191 without wrap.
REQ-030 Throughput SHALL be 5 cycles per word minimum (4 byte transfers + 1 write cycle); core_hold SHALL fall on the cycle after the final mem_we.

Reset
REQ-031 While reset=0: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, busy=0, done=0, err=0, LEN/counters/assembler=0.
REQ-032 Reset asserted mid-load SHALL abandon the load immediately; a subsequent load SHALL begin at address 0.

Verification
REQ-033 start; bytes 00 02 20 08 00 05 00 00 00 2A -> writes addr0=0x20080005, addr1=0x0000002A; done=1, core_hold=0 one cycle after second write.
REQ-034 start; bytes 00 00 -> DONE directly after second byte; mem_we never asserted; done=1, core_hold=0.
REQ-035 start; bytes 20 01 (LEN=8193) -> ERR; err=1, core_hold=1, in_ready=0, no writes.
REQ-036 Scenario REQ-033 with 0-3 random idle cycles (in_valid=0, garbage in_data) between bytes -> identical writes and final state.
REQ-037 reset pulsed low after 2 DATA bytes -> all outputs at REQ-031 values; new load of 00 01 DE AD BE EF writes addr0=0xDEADBEEF.
REQ-038 From DONE, start with 00 01 00 00 00 08 -> core_hold rises next cycle, addr0 overwritten with 0x00000008, done re-asserts.
